// File: rtl/tinker_wb_arbiter.sv
// tinker_wb_arbiter: shares the register-file write port between ALU and FPU results, age-then-round-robin.
// Optional conflict statistics counter enabled by defining TINKER_WB_STATS_EN.
module tinker_wb_arbiter #(
  parameter int DATA_W = 64,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_wb_valid,
  output logic              alu_wb_ready,
  input  logic [REG_AW-1:0] alu_wb_rd,
  input  logic [DATA_W-1:0] alu_wb_data,
  input  logic              fpu_wb_valid,
  output logic              fpu_wb_ready,
  input  logic [REG_AW-1:0] fpu_wb_rd,
  input  logic [DATA_W-1:0] fpu_wb_data,
  input  logic              rf_busy,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_src_fpu,
  output logic [15:0]       conflict_cnt
);
  logic              r_alu_full, r_fpu_full, r_tie, r_fpu_older, r_ptr;
  logic [REG_AW-1:0] r_alu_rd, r_fpu_rd;
  logic [DATA_W-1:0] r_alu_data, r_fpu_data;
  logic              w_alu_win, w_gnt_alu, w_gnt_fpu, w_alu_ld, w_fpu_ld;
  // r_tie: both entries loaded on the same edge, so the pointer breaks the tie
  assign w_alu_win    = ~r_fpu_full | (r_tie ? ~r_ptr : ~r_fpu_older);
  assign w_gnt_alu    = ~rf_busy & r_alu_full & w_alu_win;
  assign w_gnt_fpu    = ~rf_busy & r_fpu_full & ~(r_alu_full & w_alu_win);
  assign alu_wb_ready = rst_n & (~r_alu_full | w_gnt_alu);
  assign fpu_wb_ready = rst_n & (~r_fpu_full | w_gnt_fpu);
  assign w_alu_ld     = alu_wb_valid & alu_wb_ready;
  assign w_fpu_ld     = fpu_wb_valid & fpu_wb_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_full  <= 1'b0;
      r_fpu_full  <= 1'b0;
      r_tie       <= 1'b0;
      r_fpu_older <= 1'b0;
      r_ptr       <= 1'b0;
      r_alu_rd    <= '0;
      r_fpu_rd    <= '0;
      r_alu_data  <= '0;
      r_fpu_data  <= '0;
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      rf_src_fpu  <= 1'b0;
    end else begin
      r_alu_full <= w_alu_ld | (r_alu_full & ~w_gnt_alu);
      r_fpu_full <= w_fpu_ld | (r_fpu_full & ~w_gnt_fpu);
      if (w_alu_ld) begin
        r_alu_rd   <= alu_wb_rd;
        r_alu_data <= alu_wb_data;
      end
      if (w_fpu_ld) begin
        r_fpu_rd   <= fpu_wb_rd;
        r_fpu_data <= fpu_wb_data;
      end
      // a lone load is always younger than whatever the other buffer still holds
      if (w_alu_ld & w_fpu_ld) r_tie <= 1'b1;
      else if (w_alu_ld | w_fpu_ld) begin
        r_tie       <= 1'b0;
        r_fpu_older <= w_alu_ld;
      end
      if (w_gnt_alu | w_gnt_fpu) r_ptr <= w_gnt_alu;
      rf_we <= w_gnt_alu | w_gnt_fpu;
      if (w_gnt_alu | w_gnt_fpu) begin
        rf_waddr   <= w_gnt_fpu ? r_fpu_rd : r_alu_rd;
        rf_wdata   <= w_gnt_fpu ? r_fpu_data : r_alu_data;
        rf_src_fpu <= w_gnt_fpu;
      end
    end
  end
`ifdef TINKER_WB_STATS_EN
  logic [15:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else if (r_alu_full & r_fpu_full & (r_cnt != 16'hFFFF)) r_cnt <= r_cnt + 16'd1;
  end
  assign conflict_cnt = r_cnt;
`else
  assign conflict_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_tinker_wb_arbiter.sv
// tb_tinker_wb_arbiter: random stimulus against a timestamp-based reference model with a write scoreboard.
module tb_tinker_wb_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        alu_wb_valid = 1'b0, fpu_wb_valid = 1'b0, rf_busy = 1'b0;
  logic        alu_wb_ready, fpu_wb_ready, rf_we, rf_src_fpu;
  logic [4:0]  alu_wb_rd = '0, fpu_wb_rd = '0, rf_waddr;
  logic [63:0] alu_wb_data = '0, fpu_wb_data = '0, rf_wdata;
  logic [15:0] conflict_cnt;
  tinker_wb_arbiter #(.DATA_W(64), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_wb_valid(alu_wb_valid), .alu_wb_ready(alu_wb_ready), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
    .fpu_wb_valid(fpu_wb_valid), .fpu_wb_ready(fpu_wb_ready), .fpu_wb_rd(fpu_wb_rd), .fpu_wb_data(fpu_wb_data),
    .rf_busy(rf_busy), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_src_fpu(rf_src_fpu), .conflict_cnt(conflict_cnt)
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {
    logic        src;
    logic [4:0]  rd;
    logic [63:0] data;
    int          at;
  } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;
  logic        m_full[2];
  logic [4:0]  m_rd[2];
  logic [63:0] m_data[2];
  int          m_stamp[2];
  int          m_ptr, m_cnt;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask
  task automatic model_clear();
    for (int s = 0; s < 2; s++) begin
      m_full[s]  = 1'b0;
      m_stamp[s] = 0;
    end
    m_ptr = 0;
    m_cnt = 0;
    exp_q.delete();
  endtask
  function automatic int exp_cnt();
`ifdef TINKER_WB_STATS_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction
  // one cycle: drive at the falling edge, check ready/counter, advance the model across the next rising edge
  task automatic step(input logic av, input logic fv, input logic bz,
                      input logic [4:0] ard, input logic [63:0] adat,
                      input logic [4:0] frd, input logic [63:0] fdat);
    int  g;
    logic er[2];
    logic v[2];
    @(negedge clk);
    alu_wb_valid = av; fpu_wb_valid = fv; rf_busy = bz;
    alu_wb_rd = ard; alu_wb_data = adat; fpu_wb_rd = frd; fpu_wb_data = fdat;
    #1;
    chk("conflict_cnt", conflict_cnt, exp_cnt());
    g = -1;
    if (!bz) begin
      if (m_full[0] && m_full[1])
        g = (m_stamp[0] < m_stamp[1]) ? 0 : (m_stamp[1] < m_stamp[0]) ? 1 : m_ptr;
      else if (m_full[0]) g = 0;
      else if (m_full[1]) g = 1;
    end
    for (int s = 0; s < 2; s++) er[s] = !m_full[s] || g == s;
    chk("alu_ready", alu_wb_ready, er[0]);
    chk("fpu_ready", fpu_wb_ready, er[1]);
    if (m_full[0] && m_full[1] && m_cnt < 16'hFFFF) m_cnt++;
    if (g >= 0) begin
      exp_q.push_back('{src: g[0], rd: m_rd[g], data: m_data[g], at: cyc + 1});
      m_full[g] = 1'b0;
      m_ptr = 1 - g;
    end
    v[0] = av; v[1] = fv;
    for (int s = 0; s < 2; s++)
      if (v[s] && er[s]) begin
        m_full[s]  = 1'b1;
        m_rd[s]    = s == 0 ? ard : frd;
        m_data[s]  = s == 0 ? adat : fdat;
        m_stamp[s] = cyc + 1;
      end
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 5'd0, 64'd0);
  endtask
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_we"}, rf_we, 1'b0);
    chk({tag, "_waddr"}, rf_waddr, 5'd0);
    chk({tag, "_wdata"}, rf_wdata, 64'd0);
    chk({tag, "_src"}, rf_src_fpu, 1'b0);
    chk({tag, "_alu_ready"}, alu_wb_ready, 1'b0);
    chk({tag, "_fpu_ready"}, fpu_wb_ready, 1'b0);
    chk({tag, "_cnt"}, conflict_cnt, 16'd0);
  endtask
  task automatic mid_reset();
    step(1'b1, 1'b1, 1'b1, 5'd3, 64'h33, 5'd4, 64'h44);
    step(1'b1, 1'b1, 1'b1, 5'd3, 64'h35, 5'd4, 64'h46);
    step(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 5'd0, 64'd0);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1 check_reset_outputs("rst_async");
    @(posedge clk);
    #1 check_reset_outputs("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    #1;
    chk("rel_alu_ready", alu_wb_ready, 1'b1);
    chk("rel_fpu_ready", fpu_wb_ready, 1'b1);
    idle(5);
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_we", 1'b1, 1'b0);
      else begin
        mon_e = exp_q.pop_front();
        chk("wr_cycle", cyc, mon_e.at);
        chk("wr_src", rf_src_fpu, mon_e.src);
        chk("wr_addr", rf_waddr, mon_e.rd);
        chk("wr_data", rf_wdata, mon_e.data);
      end
    end
  end
  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("init_alu_ready", alu_wb_ready, 1'b1);
    chk("init_fpu_ready", fpu_wb_ready, 1'b1);
    step(1'b1, 1'b0, 1'b0, 5'd5, 64'h1234, 5'd0, 64'd0);
    idle(3);
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 1'b0, 5'd9, 64'(i), 5'd0, 64'd0);
    idle(3);
    step(1'b0, 1'b1, 1'b1, 5'd0, 64'd0, 5'd7, 64'h1);
    step(1'b1, 1'b0, 1'b1, 5'd7, 64'h2, 5'd0, 64'd0);
    idle(4);
    mid_reset();
    step(1'b1, 1'b1, 1'b0, 5'd6, 64'hA, 5'd8, 64'hB);
    idle(3);
    step(1'b1, 1'b1, 1'b0, 5'd1, 64'h11, 5'd2, 64'h22);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, 5'd0, 64'd0, 5'd0, 64'd0);
    idle(4);
    for (int i = 0; i < 600; i++) begin
      int bz_pct, v_pct;
      bz_pct = (i / 150) % 2 == 0 ? 20 : 55;
      v_pct  = (i / 100) % 2 == 0 ? 50 : 90;
      if (i == 300) mid_reset();
      step($urandom_range(99) < v_pct, $urandom_range(99) < v_pct, $urandom_range(99) < bz_pct,
           5'($urandom_range(3)), {$urandom, $urandom}, 5'($urandom_range(3)), {$urandom, $urandom});
    end
    idle(6);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
